// File: rtl/adma_pkg.sv
// Shared AXI DMA address-stream definitions: BRESP encodings and where the channel
// number sits inside the AXI ID.
package adma_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int CHN_ID_LSB = 0;

  function automatic logic bresp_is_err(input logic [1:0] resp);
    return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
  endfunction

endpackage

// File: rtl/adma_ost_cnt.sv
// Per-channel outstanding write counter.
// Optional feature: ADMA_CPL_UNEXP_CHK_EN makes the counter saturate at zero on an unexpected decrement.
module adma_ost_cnt #(
  parameter int OST_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic [OST_W-1:0] max,
  output logic [OST_W-1:0] cnt,
  output logic             full,
  output logic             underflow
);

  logic dec_eff;

  assign full      = (cnt == max);
  assign underflow = dec & (cnt == '0);

`ifdef ADMA_CPL_UNEXP_CHK_EN
  assign dec_eff = dec & ~underflow;
`else
  assign dec_eff = dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (inc && !dec_eff) cnt <= cnt + OST_W'(1);
    else if (dec_eff && !inc) cnt <= cnt - OST_W'(1);
  end

endmodule

// File: rtl/adma_as_atx_cpl_demux.sv
// Gates issues on per-channel outstanding limits and routes AXI B responses back to
// their owning DMA channel. Optional feature: ADMA_CPL_UNEXP_CHK_EN flags unexpected responses.
module adma_as_atx_cpl_demux
  import adma_pkg::*;
#(
  parameter  int DMA_CHN_NUM   = 4,
  parameter  int MST_ID_W      = 5,
  parameter  int OST_MAX       = 8,
  localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
  localparam int OST_W         = $clog2(OST_MAX + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DMA_CHN_NUM_W-1:0]            atx_chn_id,
  input  logic                                atx_vld,
  output logic                                atx_rdy,
  output logic                                m_atx_vld,
  input  logic                                m_atx_rdy,
  input  logic [MST_ID_W-1:0]                 bid,
  input  logic [1:0]                          bresp,
  input  logic                                bvalid,
  output logic                                bready,
  output logic [DMA_CHN_NUM-1:0]              cpl_vld,
  output logic [1:0]                          cpl_resp,
  input  logic [DMA_CHN_NUM-1:0]              cpl_rdy,
  output logic [DMA_CHN_NUM-1:0][OST_W-1:0]   ost_cnt,
  output logic [DMA_CHN_NUM-1:0]              err_sticky,
  input  logic [DMA_CHN_NUM-1:0]              err_clr
);

  logic [DMA_CHN_NUM-1:0]   ost_full, uflow, err_set;
  logic [DMA_CHN_NUM_W-1:0] b_chn, hold_chn;
  logic [1:0]               hold_resp;
  logic                     hold_vld, drain, b_hsk, iss_hsk, chn_ok, cap;
  logic                     unused_bid;

  assign b_chn      = bid[CHN_ID_LSB +: DMA_CHN_NUM_W];
  assign unused_bid = ^bid;
  assign chn_ok     = (int'(b_chn) < DMA_CHN_NUM);

  assign m_atx_vld = atx_vld   & ~ost_full[atx_chn_id];
  assign atx_rdy   = m_atx_rdy & ~ost_full[atx_chn_id];
  assign iss_hsk   = atx_vld & atx_rdy;

  // Draining and capturing in one cycle keeps back-to-back B at full rate.
  assign drain  = hold_vld & cpl_rdy[hold_chn];
  assign bready = ~hold_vld | drain;
  assign b_hsk  = bvalid & bready;
  assign cap    = b_hsk & chn_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_chn  <= '0;
      hold_resp <= '0;
    end else if (cap) begin
      hold_vld  <= 1'b1;
      hold_chn  <= b_chn;
      hold_resp <= bresp;
    end else if (drain) begin
      hold_vld  <= 1'b0;
    end
  end

  assign cpl_resp = hold_resp;

  for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_chn
    assign cpl_vld[c] = hold_vld & (hold_chn == DMA_CHN_NUM_W'(c));

    adma_ost_cnt #(.OST_W(OST_W)) u_ost_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (iss_hsk & (atx_chn_id == DMA_CHN_NUM_W'(c))),
      .dec       (b_hsk & (b_chn == DMA_CHN_NUM_W'(c))),
      .max       (OST_W'(OST_MAX)),
      .cnt       (ost_cnt[c]),
      .full      (ost_full[c]),
      .underflow (uflow[c])
    );
  end

`ifndef ADMA_CPL_UNEXP_CHK_EN
  logic unused_uflow;
  assign unused_uflow = ^uflow;
`endif

  always_comb begin
    err_set = '0;
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      if (b_hsk && int'(b_chn) == c) begin
`ifdef ADMA_CPL_UNEXP_CHK_EN
        err_set[c] = bresp_is_err(bresp) | uflow[c];
`else
        err_set[c] = bresp_is_err(bresp);
`endif
      end
    end
`ifdef ADMA_CPL_UNEXP_CHK_EN
    // Out-of-range channels have no owner; report them on channel 0.
    if (b_hsk && !chn_ok) err_set[0] = 1'b1;
`endif
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky <= '0;
    else        err_sticky <= err_set | (err_sticky & ~err_clr);
  end

endmodule

// File: tb/tb_adma_as_atx_cpl_demux.sv
// Directed and randomized bench for adma_as_atx_cpl_demux against a queue-free count model.
module tb_adma_as_atx_cpl_demux;
  import adma_pkg::*;

  localparam int N = 4, IDW = 5, OMAX = 8, CW = 2, OW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0]         atx_chn_id;
  logic                  atx_vld, atx_rdy, m_atx_vld, m_atx_rdy;
  logic [IDW-1:0]        bid;
  logic [1:0]            bresp, cpl_resp;
  logic                  bvalid, bready;
  logic [N-1:0]          cpl_vld, cpl_rdy, err_sticky, err_clr;
  logic [N-1:0][OW-1:0]  ost_cnt;

  adma_as_atx_cpl_demux #(.DMA_CHN_NUM(N), .MST_ID_W(IDW), .OST_MAX(OMAX)) dut (
    .clk(clk), .rst_n(rst_n), .atx_chn_id(atx_chn_id), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .m_atx_vld(m_atx_vld), .m_atx_rdy(m_atx_rdy), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .cpl_vld(cpl_vld), .cpl_resp(cpl_resp), .cpl_rdy(cpl_rdy),
    .ost_cnt(ost_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  int errors = 0, checks = 0;

  // Model: outstanding count per channel, the one held completion, sticky errors.
  int         m_cnt[N];
  bit         m_hv;
  int         m_hc;
  logic [1:0] m_hr;
  bit [N-1:0] m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    m_hv = 0; m_hc = 0; m_hr = '0; m_err = '0;
  endtask

  task automatic idle();
    atx_vld = 0; atx_chn_id = '0; m_atx_rdy = 1; bvalid = 0; bid = '0;
    bresp = BRESP_OKAY; cpl_rdy = '1; err_clr = '0;
  endtask

  task automatic check_model();
    bit full;
    bit [N-1:0] ev;
    full = (m_cnt[atx_chn_id] == OMAX);
    chk("m_atx_vld", 32'(m_atx_vld), 32'(atx_vld & !full));
    chk("atx_rdy",   32'(atx_rdy),   32'(m_atx_rdy & !full));
    chk("bready",    32'(bready),    32'(!m_hv || cpl_rdy[m_hc]));
    ev = '0;
    if (m_hv) ev[m_hc] = 1'b1;
    chk("cpl_vld", 32'(cpl_vld), 32'(ev));
    if (m_hv) chk("cpl_resp", 32'(cpl_resp), 32'(m_hr));
    for (int c = 0; c < N; c++) chk("ost_cnt", 32'(ost_cnt[c]), 32'(m_cnt[c]));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  task automatic model_edge();
    bit full, iss, drain, bh;
    int bc, old;
    full  = (m_cnt[atx_chn_id] == OMAX);
    iss   = atx_vld && m_atx_rdy && !full;
    drain = m_hv && cpl_rdy[m_hc];
    bh    = bvalid && (!m_hv || drain);
    bc    = int'(bid[CW-1:0]);
    old   = m_cnt[bc];
    if (iss) m_cnt[atx_chn_id] = m_cnt[atx_chn_id] + 1;
    m_err = m_err & ~err_clr;
    if (bh) begin
`ifdef ADMA_CPL_UNEXP_CHK_EN
      if (old == 0) m_err[bc] = 1'b1;
      else          m_cnt[bc] = m_cnt[bc] - 1;
`else
      m_cnt[bc] = (m_cnt[bc] + (1 << OW) - 1) % (1 << OW);
`endif
      if (bresp[1]) m_err[bc] = 1'b1;
      m_hv = 1; m_hc = bc; m_hr = bresp;
    end else if (drain) begin
      m_hv = 0;
    end
  endtask

  // One cycle: compare mid-cycle, advance model at the edge, return just after it.
  task automatic step();
    #1 check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_b(input int ch, input logic [1:0] r);
    bvalid = 1; bid = IDW'(ch) | IDW'($urandom_range(0, 7) << CW); bresp = r;
  endtask

  initial begin
    int cands[$];
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and pass-through gating.
    chk("rst_ost_cnt", 32'(ost_cnt), 32'h0);
    chk("rst_bready", 32'(bready), 32'h1);
    chk("rst_cpl_vld", 32'(cpl_vld), 32'h0);
    chk("rst_err", 32'(err_sticky), 32'h0);
    atx_vld = 1; atx_chn_id = 2;
    #1 chk("rst_atx_rdy", 32'(atx_rdy), 32'h1);
    chk("rst_m_atx_vld", 32'(m_atx_vld), 32'h1);

    // Single issue then OKAY completion on ch2.
    step();
    chk("ch2_cnt1", 32'(ost_cnt[2]), 32'd1);
    idle(); send_b(2, BRESP_OKAY);
    step();
    idle();
    chk("ch2_cnt0", 32'(ost_cnt[2]), 32'd0);
    chk("ch2_cpl_vld", 32'(cpl_vld), 32'b0100);
    chk("ch2_cpl_resp", 32'(cpl_resp), 32'd0);
    step();
    chk("ch2_drained", 32'(cpl_vld), 32'h0);

    // Fill ch1 to the limit; ch3 still passes.
    atx_vld = 1; atx_chn_id = 1;
    repeat (OMAX) step();
    #1 chk("ch1_full_rdy", 32'(atx_rdy), 32'h0);
    chk("ch1_full_mvld", 32'(m_atx_vld), 32'h0);
    chk("ch1_cnt_max", 32'(ost_cnt[1]), 32'd8);
    atx_chn_id = 3;
    #1 chk("ch3_rdy", 32'(atx_rdy), 32'h1);
    step();
    chk("ch3_cnt1", 32'(ost_cnt[3]), 32'd1);

    // Simultaneous issue and completion on ch0.
    idle(); atx_vld = 1; atx_chn_id = 0;
    repeat (3) step();
    chk("ch0_cnt3", 32'(ost_cnt[0]), 32'd3);
    send_b(0, BRESP_OKAY);
    step();
    chk("ch0_cnt_same", 32'(ost_cnt[0]), 32'd3);
    idle(); step();

    // Sticky error: set, then set wins over clear, then clear.
    send_b(1, BRESP_SLVERR);
    step(); idle();
    chk("err1_set", 32'(err_sticky[1]), 32'h1);
    send_b(1, BRESP_DECERR); err_clr = 4'b0010;
    step(); idle();
    chk("err1_set_wins", 32'(err_sticky[1]), 32'h1);
    err_clr = 4'b0010;
    step(); idle();
    chk("err1_clr", 32'(err_sticky[1]), 32'h0);

    // Backpressure on ch0, then drain and capture in one cycle.
    cpl_rdy = 4'b1110; send_b(0, BRESP_OKAY);
    step();
    #1 chk("bp_bready0", 32'(bready), 32'h0);
    repeat (4) step();
    chk("bp_cnt", 32'(ost_cnt[0]), 32'd2);
    cpl_rdy = '1;
    #1 chk("bp_bready1", 32'(bready), 32'h1);
    step();
    chk("bp_recapture", 32'(cpl_vld), 32'b0001);
    chk("bp_cnt1", 32'(ost_cnt[0]), 32'd1);
    idle(); step();

`ifdef ADMA_CPL_UNEXP_CHK_EN
    send_b(3, BRESP_OKAY); step();
    send_b(3, BRESP_OKAY); step(); idle();
    chk("unexp_cnt", 32'(ost_cnt[3]), 32'd0);
    chk("unexp_err", 32'(err_sticky[3]), 32'h1);
    chk("unexp_cpl", 32'(cpl_vld), 32'b1000);
    err_clr = '1; step(); idle();
`endif

    // Randomized traffic; B only for channels the model says are outstanding.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        idle(); rst_n = 1'b0;
        #1 chk("mid_rst_cnt", 32'(ost_cnt), 32'h0);
        chk("mid_rst_cpl", 32'(cpl_vld), 32'h0);
        chk("mid_rst_err", 32'(err_sticky), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      atx_vld    = ($urandom_range(0, 9) < 6);
      atx_chn_id = CW'($urandom_range(0, N - 1));
      m_atx_rdy  = ($urandom_range(0, 9) < 7);
      cpl_rdy    = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, (1 << N) - 1));
      err_clr    = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      cands.delete();
      for (int c = 0; c < N; c++) if (m_cnt[c] > 0) cands.push_back(c);
      if (cands.size() > 0 && $urandom_range(0, 9) < 6)
        send_b(cands[$urandom_range(0, cands.size() - 1)], 2'($urandom_range(0, 3)));
      else
        bvalid = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
